// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the ALU select code, operand/immediate/PC/writeback selects and datapath enables.
module mc_control_fsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        br_cond,
   output logic [3:0]  alusel,
   output logic        a_sel,
   output logic        b_sel,
   output logic [2:0]  imm_sel,
   output logic        pc_sel,
   output logic        pc_we,
   output logic        ir_we,
   output logic        reg_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd7
   } state_e;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   localparam logic [3:0] AluAdd   = 4'b0000;
   localparam logic [3:0] AluPassB = 4'b1110;

   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmU = 3'b011;
   localparam logic [2:0] ImmJ = 3'b100;

   state_e     state_q;
   logic       illegal_q;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alt;
   logic       is_load, is_store, is_branch, is_jump, legal;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign alt       = instr[30];
   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_branch = (opcode == OpBranch);
   assign is_jump   = (opcode == OpJal) || (opcode == OpJalr);
   assign legal     = (opcode == OpLui) || (opcode == OpAuipc) || is_jump || is_branch ||
                      is_load || is_store || (opcode == OpImm) || (opcode == OpReg);

   logic unused_instr;
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // sub/sra selected by alt; callers clear alt where it must be ignored.
   function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic sub_sra);
      case (f3)
         3'b000:  alu_code = sub_sra ? 4'b0001 : 4'b0000;
         3'b001:  alu_code = 4'b0111;
         3'b010:  alu_code = 4'b1000;
         3'b011:  alu_code = 4'b1001;
         3'b100:  alu_code = 4'b0100;
         3'b101:  alu_code = sub_sra ? 4'b0110 : 4'b0101;
         3'b110:  alu_code = 4'b0011;
         default: alu_code = 4'b0010;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            StFetch:  if (mem_ready) state_q <= StDecode;
            StDecode: begin
               if (legal) begin
                  state_q <= StExec;
               end else begin
                  state_q   <= StTrap;
                  illegal_q <= 1'b1;
               end
            end
            StExec: begin
               if (is_branch)                state_q <= StFetch;
               else if (is_load || is_store) state_q <= StMem;
               else                          state_q <= StWb;
            end
            StMem:    if (mem_ready) state_q <= is_load ? StWb : StFetch;
            StWb:     state_q <= StFetch;
            StTrap:   state_q <= StTrap;
            default:  state_q <= StFetch;
         endcase
      end
   end

   always_comb begin
      alusel  = AluAdd;
      a_sel   = 1'b0;
      b_sel   = 1'b0;
      imm_sel = ImmI;
      pc_sel  = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      wb_sel  = 2'b00;
      // Everything stays quiet during the reset cycle, whatever state holds.
      if (rst_n) begin
         case (state_q)
            StFetch: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            StExec: begin
               case (opcode)
                  OpReg:   alusel = alu_code(funct3, alt);
                  OpImm: begin
                     alusel = alu_code(funct3, alt && (funct3 == 3'b101));
                     b_sel  = 1'b1;
                  end
                  OpLui: begin
                     alusel  = AluPassB;
                     b_sel   = 1'b1;
                     imm_sel = ImmU;
                  end
                  OpAuipc: begin
                     a_sel   = 1'b1;
                     b_sel   = 1'b1;
                     imm_sel = ImmU;
                  end
                  OpLoad:  b_sel = 1'b1;
                  OpStore: begin
                     b_sel   = 1'b1;
                     imm_sel = ImmS;
                  end
                  OpBranch: begin
                     a_sel   = 1'b1;
                     b_sel   = 1'b1;
                     imm_sel = ImmB;
                     pc_sel  = 1'b1;
                     pc_we   = br_cond;
                  end
                  OpJal: begin
                     a_sel   = 1'b1;
                     b_sel   = 1'b1;
                     imm_sel = ImmJ;
                     pc_sel  = 1'b1;
                     pc_we   = 1'b1;
                  end
                  OpJalr: begin
                     b_sel  = 1'b1;
                     pc_sel = 1'b1;
                     pc_we  = 1'b1;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               b_sel   = 1'b1;
               imm_sel = is_store ? ImmS : ImmI;
               mem_req = 1'b1;
               mem_we  = is_store;
            end
            StWb: begin
               reg_we = 1'b1;
               if (is_load)      wb_sel = 2'b01;
               else if (is_jump) wb_sel = 2'b10;
               else              wb_sel = 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm.
module tb_mc_control_fsm;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        mem_ready;
   logic        br_cond;
   logic [3:0]  alusel;
   logic        a_sel;
   logic        b_sel;
   logic [2:0]  imm_sel;
   logic        pc_sel;
   logic        pc_we;
   logic        ir_we;
   logic        reg_we;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [2:0]  state;

   int n_cmp;
   int n_bad;

   mc_control_fsm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .instr     (instr),
      .mem_ready (mem_ready),
      .br_cond   (br_cond),
      .alusel    (alusel),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .imm_sel   (imm_sel),
      .pc_sel    (pc_sel),
      .pc_we     (pc_we),
      .ir_we     (ir_we),
      .reg_we    (reg_we),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .wb_sel    (wb_sel),
      .illegal   (illegal),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      n_cmp++; if (ir_we !== 1'b0) begin n_bad++; $display("FAIL rst_ir_we: got %b want 0", ir_we); end
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      n_cmp++; if (alusel !== 4'b0000) begin n_bad++; $display("FAIL rst_alusel: got %b want 0000", alusel); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_fetch: got %b want 1", mem_req); end
   endtask

   task automatic test_add();
      instr     = 32'h002081B3;
      mem_ready = 1'b1;
      #1;
      n_cmp++; if ({ir_we, pc_we, pc_sel} !== 3'b110) begin n_bad++; $display("FAIL add_fetch_en: got %b want 110", {ir_we, pc_we, pc_sel}); end
      step();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL add_decode_state: got %0d want 1", state); end
      n_cmp++; if ({ir_we, pc_we, mem_req, reg_we} !== 4'b0000) begin n_bad++; $display("FAIL add_decode_en: got %b want 0000", {ir_we, pc_we, mem_req, reg_we}); end
      step();
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL add_exec_state: got %0d want 2", state); end
      n_cmp++; if ({alusel, a_sel, b_sel} !== 6'b000000) begin n_bad++; $display("FAIL add_exec_sel: got %b want 000000", {alusel, a_sel, b_sel}); end
      step();
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL add_wb_state: got %0d want 4", state); end
      n_cmp++; if ({reg_we, wb_sel} !== 3'b100) begin n_bad++; $display("FAIL add_wb: got %b want 100", {reg_we, wb_sel}); end
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL add_done_state: got %0d want 0", state); end
      n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL add_single_reg_we: got %b want 0", reg_we); end
   endtask

   task automatic test_sub_srai();
      instr = 32'h402081B3;
      step();
      step();
      n_cmp++; if (alusel !== 4'b0001) begin n_bad++; $display("FAIL sub_alusel: got %b want 0001", alusel); end
      n_cmp++; if (b_sel !== 1'b0) begin n_bad++; $display("FAIL sub_b_sel: got %b want 0", b_sel); end
      step();
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL sub_done_state: got %0d want 0", state); end
      instr = 32'h4020D193;
      step();
      step();
      n_cmp++; if (alusel !== 4'b0110) begin n_bad++; $display("FAIL srai_alusel: got %b want 0110", alusel); end
      n_cmp++; if ({b_sel, imm_sel} !== 4'b1000) begin n_bad++; $display("FAIL srai_imm: got %b want 1000", {b_sel, imm_sel}); end
      step();
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL srai_done_state: got %0d want 0", state); end
   endtask

   task automatic test_jal();
      instr = 32'h008000EF;
      step();
      step();
      n_cmp++; if ({pc_we, pc_sel, a_sel} !== 3'b111) begin n_bad++; $display("FAIL jal_exec: got %b want 111", {pc_we, pc_sel, a_sel}); end
      n_cmp++; if (imm_sel !== 3'b100) begin n_bad++; $display("FAIL jal_imm_sel: got %b want 100", imm_sel); end
      step();
      n_cmp++; if ({reg_we, wb_sel} !== 3'b110) begin n_bad++; $display("FAIL jal_wb: got %b want 110", {reg_we, wb_sel}); end
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL jal_done_state: got %0d want 0", state); end
   endtask

   task automatic test_load_wait();
      int lat, memreq_cnt, waits, reg_cnt, we_seen, iter;
      logic [1:0] wb_seen;
      lat = 1; memreq_cnt = 0; waits = 0; reg_cnt = 0; we_seen = 0; iter = 0;
      wb_seen   = 2'b11;
      instr     = 32'h0000A183;
      mem_ready = 1'b1;
      step();
      while (state !== 3'd0 && iter < 20) begin
         if (state === 3'd3) begin
            mem_ready = (waits >= 2);
            waits++;
            #1;
            memreq_cnt += int'(mem_req);
            if (mem_we) we_seen = 1;
         end else begin
            mem_ready = 1'b1;
            #1;
         end
         if (state === 3'd4) begin
            reg_cnt += int'(reg_we);
            wb_seen = wb_sel;
         end
         lat++;
         iter++;
         step();
      end
      mem_ready = 1'b1;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL lw_return_fetch: got %0d want 0", state); end
      n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL lw_latency: got %0d want 7", lat); end
      n_cmp++; if (memreq_cnt != 3) begin n_bad++; $display("FAIL lw_mem_req_cycles: got %0d want 3", memreq_cnt); end
      n_cmp++; if (we_seen != 0) begin n_bad++; $display("FAIL lw_mem_we: got %0d want 0", we_seen); end
      n_cmp++; if (reg_cnt != 1) begin n_bad++; $display("FAIL lw_reg_we_count: got %0d want 1", reg_cnt); end
      n_cmp++; if (wb_seen !== 2'b01) begin n_bad++; $display("FAIL lw_wb_sel: got %b want 01", wb_seen); end
   endtask

   task automatic test_branch();
      instr   = 32'h00208463;
      br_cond = 1'b1;
      step();
      step();
      n_cmp++; if ({pc_we, pc_sel, imm_sel} !== 5'b11010) begin n_bad++; $display("FAIL beq_taken_exec: got %b want 11010", {pc_we, pc_sel, imm_sel}); end
      n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL beq_taken_reg_we: got %b want 0", reg_we); end
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL beq_taken_fetch: got %0d want 0", state); end
      br_cond = 1'b0;
      step();
      step();
      n_cmp++; if ({pc_we, pc_sel} !== 2'b01) begin n_bad++; $display("FAIL beq_nt_exec: got %b want 01", {pc_we, pc_sel}); end
      n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL beq_nt_reg_we: got %b want 0", reg_we); end
      step();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL beq_nt_fetch: got %0d want 0", state); end
   endtask

   task automatic test_trap();
      instr = 32'h0000007F;
      step();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL trap_decode: got %0d want 1", state); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL trap_early_illegal: got %b want 0", illegal); end
      step();
      n_cmp++; if ({state, illegal} !== 4'b1111) begin n_bad++; $display("FAIL trap_enter: got %b want 1111", {state, illegal}); end
      step();
      step();
      n_cmp++; if ({state, illegal} !== 4'b1111) begin n_bad++; $display("FAIL trap_hold: got %b want 1111", {state, illegal}); end
      n_cmp++; if ({mem_req, ir_we, pc_we, reg_we} !== 4'b0000) begin n_bad++; $display("FAIL trap_en: got %b want 0000", {mem_req, ir_we, pc_we, reg_we}); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      n_cmp++; if ({state, illegal} !== 4'b0000) begin n_bad++; $display("FAIL trap_reset: got %b want 0000", {state, illegal}); end
   endtask

   task automatic test_reset_mid_mem();
      instr     = 32'h0020A223;
      mem_ready = 1'b1;
      step();
      step();
      n_cmp++; if ({b_sel, imm_sel} !== 4'b1001) begin n_bad++; $display("FAIL sw_exec: got %b want 1001", {b_sel, imm_sel}); end
      mem_ready = 1'b0;
      step();
      step();
      n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL sw_mem_wait: got %0d want 3", state); end
      n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin n_bad++; $display("FAIL sw_mem_req: got %b want 11", {mem_req, mem_we}); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({mem_req, mem_we} !== 2'b00) begin n_bad++; $display("FAIL sw_rst_cycle: got %b want 00", {mem_req, mem_we}); end
      step();
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL sw_rst_fetch: got %0d want 0", state); end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      instr     = 32'h0;
      mem_ready = 1'b0;
      br_cond   = 1'b0;
      test_reset();
      test_add();
      test_sub_srai();
      test_jal();
      test_load_wait();
      test_branch();
      test_trap();
      test_reset_mid_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
